ws_result_deskew: RTL
=====================

WS_RESULT_DESKEW -- requirements
Module: ws_result_deskew

Interface
REQ-001 SHALL have parameter SIZE, default 16, the array edge length and number of result columns.
REQ-002 SHALL have parameter LAT, default 16, the cycles from start to column 0 of row 0 being valid on sum_in[0].
REQ-003 SHALL have parameter DEPTH, default 4, the output FIFO depth in aligned rows (power of two, >=2).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on the rising edge.
REQ-005 SHALL have port rst_n, input, 1, the reset: synchronous, active-low.
REQ-006 SHALL have port start, input, 1, a one-cycle pulse in the cycle the first activation element enters the array.
REQ-007 SHALL have port row_cnt, input, 16, the number of result rows in the batch, sampled with start.
REQ-008 SHALL have port relu_en, input, 1, the ReLU enable, sampled with start (see Configuration).
REQ-009 SHALL have port sum_in[SIZE], input, signed 32 each, the staggered column sums from the array bottom edge.
REQ-010 SHALL have port out_valid, output, 1, meaning an aligned row is presented.
REQ-011 SHALL have port out_ready, input, 1, the consumer acceptance.
REQ-012 SHALL have port out_row[SIZE], output, signed 32 each, the aligned result row.
REQ-013 SHALL have port out_last, output, 1, marking the final row of the batch, qualified by out_valid.
REQ-014 SHALL have port busy, output, 1, high whenever the FSM is not in IDLE.
REQ-015 SHALL have port ovf, output, 1, a sticky flag indicating a row was dropped because the FIFO was full.

Function
REQ-016 SHALL implement FSM IDLE -> WAIT -> CAPTURE -> DRAIN -> IDLE.
REQ-017 IDLE: start=1 with row_cnt!=0 SHALL go to WAIT, latch row_cnt and relu_en, and clear ovf; start with row_cnt==0 SHALL be ignored.
REQ-018 start while busy SHALL be ignored with no state change.
REQ-019 Taking T0 as the cycle start is sampled, column c of row v SHALL be valid on sum_in[c] in cycle T0+LAT+v+c.
REQ-020 Column c SHALL be delayed by SIZE-1-c register stages so that row v is aligned in cycle Tv=T0+LAT+SIZE-1+v; column SIZE-1 SHALL be undelayed.
REQ-021 WAIT SHALL count to the first aligned cycle, then go to CAPTURE.
REQ-022 CAPTURE SHALL write one aligned row per cycle into the FIFO for row_cnt consecutive cycles, then go to DRAIN.
REQ-023 The write SHALL carry a last tag equal to 1 for row row_cnt-1.
REQ-024 The array cannot stall; a capture when the FIFO is full with no same-cycle pop SHALL drop the row and set ovf.
REQ-025 A capture when the FIFO is full with a same-cycle pop SHALL succeed.
REQ-026 The row written in cycle Tv SHALL be visible on out_valid/out_row in Tv+1 if the FIFO was empty.
REQ-027 Handshake: a pop SHALL occur iff out_valid && out_ready.
REQ-028 out_row and out_last SHALL hold stable while out_valid && !out_ready.
REQ-029 DRAIN SHALL go to IDLE in the cycle after the FIFO becomes empty; busy SHALL drop in that IDLE cycle.
REQ-030 Pointer wrap SHALL be modulo DEPTH; full and empty SHALL be distinguished by an extra pointer bit.
REQ-031 Data SHALL pass unmodified except for REQ-035; no arithmetic widening.

Reset
REQ-032 rst_n=0 at a clock edge SHALL force: state IDLE, FIFO empty, counters 0, delay registers 0, out_valid=0, out_last=0, out_row all 0, busy=0, ovf=0.
REQ-033 Reset asserted mid-batch SHALL discard all buffered and in-flight rows; no partial row SHALL appear after reset release.
REQ-034 Outputs SHALL be valid in the first cycle after rst_n returns high.

Configuration
REQ-035 With WS_RESULT_DESKEW_RELU_EN defined, if latched relu_en=1, negative elements SHALL be written as 0 and non-negative elements unchanged, with no added latency.
REQ-036 Without WS_RESULT_DESKEW_RELU_EN, relu_en SHALL be ignored and no ReLU logic SHALL be present.

Verification (SIZE=4, LAT=4, DEPTH=4)
REQ-037 start at T0 with row_cnt=2 and column c of row v = 10*v+c, out_ready=1 -> out_row={0,1,2,3} valid at T0+8, {10,11,12,13} at T0+9 with out_last=1, busy low at T0+10.
REQ-038 row_cnt=6, out_ready=0 -> 4 rows buffered, rows 4 and 5 dropped, ovf=1; then out_ready=1 -> rows 0..3 drain in order, no out_last seen, ovf holds until the next start.
REQ-039 FIFO full and out_ready=1 during capture -> no drop, ovf=0, rows delivered in order.
REQ-040 rst_n=0 for one cycle at T0+7 of a 3-row batch -> all outputs 0, state IDLE next cycle, no stale row after release.
REQ-041 start while busy, and start with row_cnt=0 in IDLE -> ignored, no change to state or outputs.
REQ-042 Macro defined, relu_en=1, row {-5,7,-1,0} -> {0,7,0,0}; macro undefined -> {-5,7,-1,0}.

Source files
------------

// File: rtl/ws_result_deskew_if.sv
// Aligned-row output channel of ws_result_deskew: valid/ready handshake carrying one result row and its last tag.
interface ws_result_deskew_if #(
  parameter int SIZE = 16
);
  logic               out_valid;
  logic               out_ready;
  logic               out_last;
  logic signed [31:0] out_row [SIZE];

  modport master (output out_valid, output out_last, output out_row, input out_ready);
  modport slave  (input out_valid, input out_last, input out_row, output out_ready);
endinterface

// File: rtl/ws_result_deskew.sv
// Deskews staggered systolic column sums into whole rows and queues them; a row shows one cycle after alignment.
// The array cannot stall, so rows arriving at a full FIFO with no pop are dropped (sticky ovf); WS_RESULT_DESKEW_RELU_EN adds ReLU.
module ws_result_deskew #(
  parameter int SIZE  = 16,
  parameter int LAT   = 16,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [15:0]        row_cnt,
  input  logic               relu_en,
  input  logic signed [31:0] sum_in [SIZE],
  ws_result_deskew_if.master out_if,
  output logic               busy,
  output logic               ovf
);
  localparam int          AW        = $clog2(DEPTH);
  localparam int          WAIT_CYC  = LAT + SIZE - 2;
  localparam logic [15:0] WAIT_LAST = 16'(WAIT_CYC - 1);
  localparam logic [AW:0] PTR_ONE   = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPTURE, S_DRAIN} state_t;

  state_t             state_q, state_d;
  logic [15:0]        wait_cnt_q, wait_cnt_d;
  logic [15:0]        row_q, row_d;
  logic [15:0]        rows_q, rows_d;
  logic               ovf_q, ovf_d;
  logic [AW:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic signed [31:0] dly_q [SIZE-1][SIZE-1];
  logic signed [31:0] dly_d [SIZE-1][SIZE-1];
  logic signed [31:0] mem_q [DEPTH][SIZE];
  logic signed [31:0] mem_d [DEPTH][SIZE];
  logic               last_q [DEPTH];
  logic               last_d [DEPTH];
  logic signed [31:0] aligned [SIZE];
  logic signed [31:0] wr_row [SIZE];
  logic               empty, full, pop, capture, wr_en, wr_last;

`ifdef WS_RESULT_DESKEW_RELU_EN
  logic relu_q, relu_d;
`else
  logic unused_relu;
  assign unused_relu = relu_en;
`endif

  // Column c has already waited c cycles in the array; SIZE-1-c more stages line it up with the last column.
  always_comb begin
    for (int c = 0; c < SIZE - 1; c++) aligned[c] = dly_q[c][SIZE-2-c];
    aligned[SIZE-1] = sum_in[SIZE-1];
  end

  always_comb begin
    for (int c = 0; c < SIZE; c++) begin
`ifdef WS_RESULT_DESKEW_RELU_EN
      wr_row[c] = (relu_q && aligned[c] < 0) ? '0 : aligned[c];
`else
      wr_row[c] = aligned[c];
`endif
    end
  end

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop     = !empty && out_if.out_ready;
  assign capture = (state_q == S_CAPTURE);
  assign wr_en   = capture && (!full || pop);
  assign wr_last = (row_q == rows_q - 16'd1);

  assign out_if.out_valid = !empty;
  assign out_if.out_last  = !empty && last_q[rptr_q[AW-1:0]];
  assign busy             = (state_q != S_IDLE);
  assign ovf              = ovf_q;

  always_comb begin
    for (int c = 0; c < SIZE; c++) out_if.out_row[c] = empty ? '0 : mem_q[rptr_q[AW-1:0]][c];
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    row_d      = row_q;
    rows_d     = rows_q;
    ovf_d      = ovf_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    mem_d      = mem_q;
    last_d     = last_q;
`ifdef WS_RESULT_DESKEW_RELU_EN
    relu_d     = relu_q;
`endif
    for (int c = 0; c < SIZE - 1; c++) begin
      dly_d[c][0] = sum_in[c];
      for (int s = 1; s < SIZE - 1; s++) dly_d[c][s] = dly_q[c][s-1];
    end

    if (pop) rptr_d = rptr_q + PTR_ONE;
    if (wr_en) begin
      mem_d[wptr_q[AW-1:0]]  = wr_row;
      last_d[wptr_q[AW-1:0]] = wr_last;
      wptr_d                 = wptr_q + PTR_ONE;
    end
    if (capture && full && !pop) ovf_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start && (row_cnt != 16'd0)) begin
          rows_d     = row_cnt;
          row_d      = 16'd0;
          wait_cnt_d = 16'd0;
          ovf_d      = 1'b0;
`ifdef WS_RESULT_DESKEW_RELU_EN
          relu_d     = relu_en;
`endif
          state_d    = (WAIT_CYC == 0) ? S_CAPTURE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) state_d = S_CAPTURE;
        else                         wait_cnt_d = wait_cnt_q + 16'd1;
      end
      S_CAPTURE: begin
        if (wr_last) state_d = S_DRAIN;
        else         row_d   = row_q + 16'd1;
      end
      S_DRAIN: begin
        if (rptr_d == wptr_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      row_q      <= '0;
      rows_q     <= '0;
      ovf_q      <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
`ifdef WS_RESULT_DESKEW_RELU_EN
      relu_q     <= 1'b0;
`endif
      for (int c = 0; c < SIZE - 1; c++)
        for (int s = 0; s < SIZE - 1; s++) dly_q[c][s] <= '0;
      for (int d = 0; d < DEPTH; d++) begin
        last_q[d] <= 1'b0;
        for (int c = 0; c < SIZE; c++) mem_q[d][c] <= '0;
      end
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      row_q      <= row_d;
      rows_q     <= rows_d;
      ovf_q      <= ovf_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
`ifdef WS_RESULT_DESKEW_RELU_EN
      relu_q     <= relu_d;
`endif
      dly_q      <= dly_d;
      mem_q      <= mem_d;
      last_q     <= last_d;
    end
  end
endmodule
